// File: rtl/multicycle_controller.sv
// Multicycle main control FSM for the RV32 core (FETCH/DECODE/EXEC/MEM/WB).
// Define CTRL_PERF_EN to add the retired-instruction counter output retired_cnt.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned PERF_W      = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_is_data,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] mem_to_reg,
    output logic       illegal,
    output logic       mem_fault,
    output logic [2:0] state
`ifdef CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] retired_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam int unsigned WC_W =
        (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    if (PERF_W == 0) begin : g_bad_perf_w
        $error("PERF_W must be nonzero");
    end

    state_t          state_q, state_d;
    logic [6:0]      op_q;
    logic [WC_W-1:0] wait_cnt;
    logic            illegal_q, mem_fault_q;
    logic            waiting, timeout, set_illegal;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LW, OP_SW,
            OP_BR, OP_LUI, OP_JAL: is_legal = 1'b1;
            default:               is_legal = 1'b0;
        endcase
    endfunction

    assign waiting = (state_q == S_FETCH || state_q == S_MEM) && !mem_ready;
    assign timeout = (MEM_TIMEOUT != 0) && waiting &&
                     (wait_cnt == WC_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_FETCH;
            op_q        <= '0;
            wait_cnt    <= '0;
            illegal_q   <= 1'b0;
            mem_fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                op_q <= opcode;
            if (set_illegal)
                illegal_q <= 1'b1;
            if (timeout)
                mem_fault_q <= 1'b1;
            // Counts consecutive stalled cycles of one request only
            if (waiting && state_d == state_q)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
        end
    end

    // Everything is forced low while reset is held, aborting any instruction
    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_is_data = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'b00;
        alu_src     = 1'b0;
        alu_op      = 2'b00;
        reg_write   = 1'b0;
        mem_to_reg  = 2'b00;
        if (reset_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else if (timeout) begin
                        state_d = S_FAULT;
                    end
                end
                S_DECODE: begin
                    if (is_legal(opcode)) begin
                        state_d = S_EXEC;
                    end else begin
                        set_illegal = 1'b1;
                        state_d     = S_FAULT;
                    end
                end
                S_EXEC: begin
                    alu_src = !(op_q == OP_R || op_q == OP_BR);
                    case (op_q)
                        OP_R, OP_I: begin
                            alu_op  = 2'b10;
                            state_d = S_WB;
                        end
                        OP_LUI: begin
                            alu_op  = 2'b11;
                            state_d = S_WB;
                        end
                        OP_LW, OP_SW: state_d = S_MEM;
                        OP_BR: begin
                            alu_op   = 2'b01;
                            pc_write = branch_taken;
                            pc_src   = 2'b01;
                            state_d  = S_FETCH;
                        end
                        OP_JAL: begin
                            pc_write = 1'b1;
                            pc_src   = 2'b10;
                            state_d  = S_WB;
                        end
                        default: state_d = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    mem_req     = 1'b1;
                    mem_is_data = 1'b1;
                    mem_we      = (op_q == OP_SW);
                    if (mem_ready)
                        state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
                    else if (timeout)
                        state_d = S_FAULT;
                end
                S_WB: begin
                    reg_write = 1'b1;
                    if (op_q == OP_LW)
                        mem_to_reg = 2'b01;
                    else if (op_q == OP_JAL)
                        mem_to_reg = 2'b10;
                    state_d = S_FETCH;
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign illegal   = reset_n & illegal_q;
    assign mem_fault = reset_n & mem_fault_q;
    assign state     = reset_n ? state_q : 3'd0;

`ifdef CTRL_PERF_EN
    logic              retire;
    logic [PERF_W-1:0] retired_q;

    assign retire = reset_n &&
        ((state_q == S_WB) ||
         (state_q == S_MEM && op_q == OP_SW && mem_ready) ||
         (state_q == S_EXEC && op_q == OP_BR));

    always_ff @(posedge clk) begin
        if (!reset_n)
            retired_q <= '0;
        else if (retire)
            retired_q <= retired_q + 1'b1;
    end

    assign retired_cnt = reset_n ? retired_q : '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction expected
// cycle traces built from the instruction-class rules, random waits/opcodes.
module tb_multicycle_controller;

    localparam int MT = 4;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       branch_taken;
    logic       mem_req, mem_we, mem_is_data, ir_write, pc_write;
    logic [1:0] pc_src, alu_op, mem_to_reg;
    logic       alu_src, reg_write, illegal, mem_fault;
    logic [2:0] state;
`ifdef CTRL_PERF_EN
    logic [31:0] retired_cnt;
`endif

    multicycle_controller #(.MEM_TIMEOUT(MT), .PERF_W(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_is_data  (mem_is_data),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .illegal      (illegal),
        .mem_fault    (mem_fault),
        .state        (state)
`ifdef CTRL_PERF_EN
        ,
        .retired_cnt  (retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          rn;
    bit          ill_m, mf_m;
    int unsigned perf_m;
    logic [6:0]  legal_ops [7];
    logic [17:0] obs;

    assign obs = {state, mem_req, mem_we, mem_is_data, ir_write, pc_write,
                  pc_src, alu_src, alu_op, reg_write, mem_to_reg,
                  illegal, mem_fault};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [17:0] ev(input int st, input int req,
        input int we, input int isd, input int irw, input int pcw,
        input int pcs, input int as, input int aop, input int rw,
        input int m2r);
        return {st[2:0], req[0], we[0], isd[0], irw[0], pcw[0], pcs[1:0],
                as[0], aop[1:0], rw[0], m2r[1:0], ill_m, mf_m};
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic bit is_legal_op(input logic [6:0] op);
        foreach (legal_ops[k])
            if (legal_ops[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    // ALU controls only matter in EXEC, mem_to_reg only in WB,
    // pc_src only when PC is written (or for a branch in EXEC).
    task automatic cyc(input logic rdy, input logic [6:0] opc,
                       input logic bt, input logic [17:0] exp,
                       input string tag);
        logic [17:0] m;
        @(negedge clk);
        reset_n      = rn;
        mem_ready    = rdy;
        opcode       = opc;
        branch_taken = bt;
        #1;
        m = '1;
        if (exp[17:15] != 3'd2) m[7:5] = '0;
        if (exp[17:15] != 3'd4) m[3:2] = '0;
        if (!exp[10] && !(exp[17:15] == 3'd2 && exp[6:5] == 2'b01))
            m[9:8] = '0;
        check(tag, 32'(obs & m), 32'(exp & m));
`ifdef CTRL_PERF_EN
        check("retired", retired_cnt, rn ? perf_m : 32'd0);
`endif
    endtask

    task automatic do_reset(input int n);
        rn = 1'b0;
        for (int i = 0; i < n; i++)
            cyc(rbit(), rop(), rbit(), 18'd0, "reset");
        ill_m  = 1'b0;
        mf_m   = 1'b0;
        perf_m = 0;
        rn     = 1'b1;
    endtask

    task automatic fault_cycles(input int n);
        for (int i = 0; i < n; i++)
            cyc(rbit(), rop(), rbit(), ev(5,0,0,0,0,0,0,0,0,0,0), "fault");
    endtask

    // The MT-th consecutive stalled cycle of a request ends in FAULT
    task automatic wait_phase(input int st, input int we, input int isd,
                              input int w, output bit flt);
        flt = 1'b0;
        for (int i = 0; i < w; i++) begin
            cyc(1'b0, rop(), rbit(), ev(st,1,we,isd,0,0,0,0,0,0,0), "wait");
            if (i == MT - 1) begin
                mf_m = 1'b1;
                flt  = 1'b1;
                return;
            end
        end
    endtask

    task automatic do_instr(input logic [6:0] opc, input int fw,
                            input int mw, input logic bt);
        bit flt;
        int as, aop, pcw, pcs, m2r, is_sw;
        bit to_mem, to_wb;
        wait_phase(0, 0, 0, fw, flt);
        if (flt) begin fault_cycles(3); return; end
        cyc(1'b1, rop(), rbit(), ev(0,1,0,0,1,1,0,0,0,0,0), "fetch");
        cyc(rbit(), opc, rbit(), ev(1,0,0,0,0,0,0,0,0,0,0), "decode");
        if (!is_legal_op(opc)) begin
            ill_m = 1'b1;
            fault_cycles(3);
            return;
        end
        as = 1; aop = 0; pcw = 0; pcs = 0; m2r = 0;
        to_mem = 1'b0; to_wb = 1'b1;
        is_sw = (opc == OP_SW) ? 1 : 0;
        case (opc)
            OP_R:   begin as = 0; aop = 2; end
            OP_I:   aop = 2;
            OP_LUI: aop = 3;
            OP_LW:  begin to_mem = 1'b1; m2r = 1; end
            OP_SW:  begin to_mem = 1'b1; to_wb = 1'b0; end
            OP_BR:  begin as = 0; aop = 1; pcw = int'(bt); pcs = 1;
                          to_wb = 1'b0; end
            OP_JAL: begin pcw = 1; pcs = 2; m2r = 2; end
            default: ;
        endcase
        cyc(rbit(), rop(), bt, ev(2,0,0,0,0,pcw,pcs,as,aop,0,0), "exec");
        if (opc == OP_BR) perf_m++;
        if (to_mem) begin
            wait_phase(3, is_sw, 1, mw, flt);
            if (flt) begin fault_cycles(3); return; end
            cyc(1'b1, rop(), rbit(), ev(3,1,is_sw,1,0,0,0,0,0,0,0), "mem");
            if (opc == OP_SW) perf_m++;
        end
        if (to_wb) begin
            cyc(rbit(), rop(), rbit(), ev(4,0,0,0,0,0,0,0,0,1,m2r), "wb");
            perf_m++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] bad;
        legal_ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_BR, OP_LUI, OP_JAL};
        rn = 1'b0; reset_n = 1'b0; mem_ready = 1'b0;
        opcode = '0; branch_taken = 1'b0;
        ill_m = 1'b0; mf_m = 1'b0; perf_m = 0;

        do_reset(2);
        do_instr(OP_R, 0, 0, 1'b0);
        do_instr(OP_LW, 0, 3, 1'b0);
        do_instr(OP_BR, 0, 0, 1'b1);
        do_instr(OP_BR, 0, 0, 1'b0);
        repeat (3) do_instr(OP_SW, 0, 0, 1'b0);
        foreach (legal_ops[k])
            do_instr(legal_ops[k], $urandom_range(0, 3),
                     $urandom_range(0, 3), rbit());
        do_instr(OP_I, 3, 0, 1'b0);
        do_instr(OP_SW, 0, 3, 1'b0);
        repeat (300)
            do_instr(legal_ops[$urandom_range(0, 6)], $urandom_range(0, 3),
                     $urandom_range(0, 3), rbit());

        cyc(1'b1, rop(), rbit(), ev(0,1,0,0,1,1,0,0,0,0,0), "fetch");
        cyc(rbit(), OP_JAL, rbit(), ev(1,0,0,0,0,0,0,0,0,0,0), "decode");
        do_reset(2);
        do_instr(OP_LW, 1, 1, 1'b0);

        do_instr(7'b1111111, 0, 0, 1'b0);
        do_reset(2);
        do_instr(OP_R, 0, 0, 1'b0);
        bad = rop();
        while (is_legal_op(bad)) bad = rop();
        do_instr(bad, 1, 0, 1'b0);
        do_reset(1);

        do_instr(OP_R, MT, 0, 1'b0);
        do_reset(2);
        do_instr(OP_LW, 0, MT + 2, 1'b0);
        do_reset(2);
        do_instr(OP_SW, 2, MT, 1'b0);
        do_reset(2);
        do_instr(OP_JAL, 0, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
